// File: rtl/adc_capture.sv
// adc_capture: reads a 12-bit serial ADC frame on each sample tick and presents
// the centred, scaled result to a downstream biquad with a sample strobe.
//
// Ports
//   clk       in   1   system clock
//   rst_n     in   1   asynchronous active-low reset
//   en        in   1   enables the sample-tick counter
//   adc_sdo   in   1   ADC serial data, MSB first
//   adc_cs_n  out  1   ADC chip select, active-low
//   adc_sclk  out  1   ADC serial clock, idles high
//   x         out  32  signed centred sample ((code - 2048) <<< SHIFT)
//   outsclk   out  1   filter sample clock, high for STROBE_HI cycles after x updates
//   overrun   out  1   sticky: a tick arrived while a frame was in progress
module adc_capture #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned STROBE_HI     = 16,
    parameter int unsigned SHIFT         = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               adc_sdo,
    output logic               adc_cs_n,
    output logic               adc_sclk,
    output logic signed [31:0] x,
    output logic               outsclk,
    output logic               overrun
);

    localparam int unsigned CNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned STB_W  = (STROBE_HI > 1) ? $clog2(STROBE_HI) : 1;
    localparam int unsigned BITS   = 16;
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned CODE_W = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_LATCH,
        S_STROBE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bits;
    logic [STB_W-1:0]    r_strobe;
    logic [CODE_W-1:0]   r_shift;
    logic                w_tick;
    logic signed [31:0]  w_centred;
    logic signed [31:0]  w_x;

    // Sample tick: one cycle at terminal count while enabled
    assign w_tick = en && (r_tick_cnt == CNT_W'(SAMPLE_PERIOD - 1));

    // Offset-binary code to signed centred value, then scaled
    assign w_centred = $signed({20'd0, r_shift}) - 32'sd2048;
    assign w_x       = w_centred <<< SHIFT;

    // Tick counter: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (!en || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    // Frame sequencer. Only 12 bits are kept in the shift register, so the
    // four leading don't-care bits fall off the top by the end of the frame.
    // x is loaded on the same edge that ends CONV, so it is already valid
    // during the single LATCH cycle and outsclk rises one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bits   <= '0;
            r_strobe <= '0;
            r_shift  <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            x        <= '0;
            outsclk  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (w_tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        adc_cs_n <= 1'b0;
                        r_div    <= '0;
                        r_bits   <= '0;
                        r_shift  <= '0;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (r_bits == BIT_W'(BITS)) begin
                        adc_cs_n <= 1'b1;
                        x        <= w_x;
                        r_state  <= S_LATCH;
                    end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
                        r_div    <= '0;
                        adc_sclk <= ~adc_sclk;
                        // Rising edge of sclk: capture the bit the ADC is presenting
                        if (!adc_sclk) begin
                            r_shift <= {r_shift[CODE_W-2:0], adc_sdo};
                            r_bits  <= r_bits + BIT_W'(1);
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_LATCH: begin
                    outsclk  <= 1'b1;
                    r_strobe <= '0;
                    r_state  <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_strobe == STB_W'(STROBE_HI - 1)) begin
                        outsclk <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_strobe <= r_strobe + STB_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
`timescale 1ns/1ps
// tb_adc_capture: two instances (default timing; fast period with SHIFT=4),
// a serial ADC model per instance, a frame-level timing model checked every
// cycle, and directed literal checks on the key timing points.
module tb_adc_capture;

    localparam int D    = 4;
    localparam int SH   = 16;
    localparam int SP0  = 1000;
    localparam int SP1  = 100;
    localparam int SHF0 = 0;
    localparam int SHF1 = 4;
    localparam logic [35:0] RST_OUT = 36'hC_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst0 = 1'b0, en0 = 1'b0, sdo0 = 1'b0;
    logic rst1 = 1'b0, en1 = 1'b0, sdo1 = 1'b0;
    logic cs0, sclk0, os0, ov0, cs1, sclk1, os1, ov1;
    logic [31:0] x0, x1;

    int tests = 0;
    int fails = 0;
    logic done0 = 1'b0, done1 = 1'b0;

    adc_capture #(.CLK_DIV(D), .SAMPLE_PERIOD(SP0), .STROBE_HI(SH), .SHIFT(SHF0)) u_dut0 (
        .clk(clk), .rst_n(rst0), .en(en0), .adc_sdo(sdo0), .adc_cs_n(cs0),
        .adc_sclk(sclk0), .x(x0), .outsclk(os0), .overrun(ov0));

    adc_capture #(.CLK_DIV(D), .SAMPLE_PERIOD(SP1), .STROBE_HI(SH), .SHIFT(SHF1)) u_dut1 (
        .clk(clk), .rst_n(rst1), .en(en1), .adc_sdo(sdo1), .adc_cs_n(cs1),
        .adc_sclk(sclk1), .x(x1), .outsclk(os1), .overrun(ov1));

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [35:0] act_out(input int i);
        if (i == 0) return {cs0, sclk0, os0, ov0, x0};
        return {cs1, sclk1, os1, ov1, x1};
    endfunction

    function automatic logic get_cs(input int i);
        return (i == 0) ? cs0 : cs1;
    endfunction

    function automatic logic get_sclk(input int i);
        return (i == 0) ? sclk0 : sclk1;
    endfunction

    function automatic logic [31:0] get_x(input int i);
        return (i == 0) ? x0 : x1;
    endfunction

    // ADC word returned on the k-th frame of instance i (top nibble is junk)
    function automatic logic [15:0] word_of(input int i, input int k);
        logic [15:0] w;
        if (i == 0) begin
            case (k % 6)
                0:       w = 16'hA800;
                1:       w = 16'h5FFF;
                2:       w = 16'h3000;
                3:       w = 16'hF123;
                4:       w = 16'h0ABC;
                default: w = 16'h0801;
            endcase
        end else begin
            case (k % 4)
                0:       w = 16'hFFFF;
                1:       w = 16'h0000;
                2:       w = 16'h0800;
                default: w = 16'h07FF;
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] xval(input logic [15:0] w, input int shf);
        int code;
        code = int'(w[11:0]);
        return 32'((code - 2048) * (1 << shf));
    endfunction

    // Serial ADC: presents the next bit after each falling sclk edge
    logic [15:0] acur[2];
    int          arises[2];
    int          aidx[2] = '{0, 0};
    logic        apcs[2] = '{1'b1, 1'b1};
    logic        apsc[2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic c, s, b;
            logic [15:0] w;
            c = get_cs(i);
            s = get_sclk(i);
            b = (i == 0) ? sdo0 : sdo1;
            if (!c && apcs[i]) begin
                acur[i]   = word_of(i, aidx[i]);
                aidx[i]   = aidx[i] + 1;
                arises[i] = 0;
                w = acur[i];
                b = w[15];
            end else if (!c && apsc[i] && !s && arises[i] < 16) begin
                w = acur[i];
                b = w[4'(15 - arises[i])];
            end else if (!c && !apsc[i] && s) begin
                arises[i] = arises[i] + 1;
            end
            apcs[i] = c;
            apsc[i] = s;
            if (i == 0) sdo0 = b; else sdo1 = b;
        end
    end

    // Frame-level model: outputs as a function of cycles since the accepted tick
    int          ph[2];
    int          fst[2];
    int          widx[2] = '{0, 0};
    logic [15:0] fw[2];
    logic [31:0] xe[2];
    logic        oe[2];
    logic        prst[2];
    logic        pen[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sp, shf, d;
            logic r, e, ecs, esc, eos;
            logic [35:0] req;
            sp  = (i == 0) ? SP0 : SP1;
            shf = (i == 0) ? SHF0 : SHF1;
            r   = (i == 0) ? rst0 : rst1;
            e   = (i == 0) ? en0 : en1;
            if (!r) begin
                ph[i] = 0; fst[i] = -1; xe[i] = '0; oe[i] = 1'b0;
                prst[i] = 1'b1; pen[i] = 1'b0;
                req = RST_OUT;
            end else begin
                if (prst[i] || !pen[i]) ph[i] = 0;
                else ph[i] = (ph[i] + 1) % sp;
                ecs = 1'b1; esc = 1'b1; eos = 1'b0;
                if (fst[i] >= 0) begin
                    d = cyc - fst[i];
                    if (d >= 3 + 32*D + SH) begin
                        fst[i] = -1;
                    end else begin
                        if (d >= 1 && d <= 1 + 32*D) ecs = 1'b0;
                        if (d >= 1 && d <= 32*D && ((d - 1) / D) % 2 == 1) esc = 1'b0;
                        if (d == 2 + 32*D) xe[i] = xval(fw[i], shf);
                        if (d >= 3 + 32*D && d <= 2 + 32*D + SH) eos = 1'b1;
                    end
                end
                req = {ecs, esc, eos, oe[i], xe[i]};
                if (e && ph[i] == sp - 1) begin
                    if (fst[i] < 0) begin
                        fst[i]  = cyc;
                        fw[i]   = word_of(i, widx[i]);
                        widx[i] = widx[i] + 1;
                    end else begin
                        oe[i] = 1'b1;
                    end
                end
                prst[i] = 1'b0;
                pen[i]  = e;
            end
            check((i == 0) ? "dut0_outputs" : "dut1_outputs", act_out(i), req);
        end
    end

    task automatic drive_step();
        @(posedge clk); #1;
    endtask

    task automatic sample_step();
        @(negedge clk); #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) sample_step();
    endtask

    task automatic wait_cs_fall(input int i, input int bound, output int fc);
        logic p, c;
        fc = -1;
        p  = get_cs(i);
        for (int k = 0; k < bound; k++) begin
            sample_step();
            c = get_cs(i);
            if (p && !c) begin
                fc = cyc;
                break;
            end
            p = c;
        end
        check("cs_fall_seen", 36'(fc >= 0), 36'(1));
    endtask

    task automatic wait_x_change(input int i, input int bound, output int xc);
        logic [31:0] x_start;
        xc = -1;
        x_start = get_x(i);
        for (int k = 0; k < bound; k++) begin
            sample_step();
            if (get_x(i) !== x_start) begin
                xc = cyc;
                break;
            end
        end
        check("x_change_seen", 36'(xc >= 0), 36'(1));
    endtask

    // Instance 0: default timing, en drop mid-frame, reset mid-frame
    initial begin : p_dut0
        int rel, f0, f1, f2, f3, f4, f5, xc, oh, ol, lowc, rises, edges, falls, e1;
        logic ps, pc;
        repeat (3) drive_step();
        check("dut0_reset_values", act_out(0), RST_OUT);
        drive_step(); rst0 = 1'b1; en0 = 1'b1; rel = cyc;

        wait_cs_fall(0, 1100, f0);
        check("dut0_first_tick_delay", 36'(f0 - rel), 36'(1000));
        lowc = 1; rises = 0; ps = sclk0;
        for (int k = 0; k < 200; k++) begin
            sample_step();
            if (!ps && sclk0) rises++;
            ps = sclk0;
            if (cs0) break;
            lowc++;
        end
        check("dut0_cs_low_cycles", 36'(lowc), 36'(129));
        check("dut0_sclk_rises", 36'(rises), 36'(16));
        check("dut0_x_code800", 36'(x0), 36'(0));

        wait_cs_fall(0, 1100, f1);
        check("dut0_tick_spacing", 36'(f1 - f0), 36'(1000));
        wait_x_change(0, 200, xc);
        check("dut0_x_update_time", 36'(xc - (f1 - 1)), 36'(130));
        check("dut0_x_codeFFF", 36'(x0), 36'(2047));
        oh = -1; ol = -1;
        for (int k = 0; k < 40 && ol < 0; k++) begin
            sample_step();
            if (os0 && oh < 0) oh = cyc;
            if (!os0 && oh >= 0) ol = cyc;
        end
        check("dut0_outsclk_rise", 36'(oh - (f1 - 1)), 36'(131));
        check("dut0_outsclk_last_high", 36'(ol - 1 - (f1 - 1)), 36'(146));

        wait_cs_fall(0, 1100, f2);
        wait_x_change(0, 200, xc);
        check("dut0_x_code000", 36'(x0), 36'(32'hFFFF_F800));

        // Drop en at the 8th sclk edge of the next frame
        wait_cs_fall(0, 1100, f3);
        edges = 0; ps = sclk0;
        for (int k = 0; k < 200 && edges < 8; k++) begin
            sample_step();
            if (sclk0 != ps) edges++;
            ps = sclk0;
        end
        check("dut0_sclk_edges_before_en_drop", 36'(edges), 36'(8));
        drive_step(); en0 = 1'b0;
        wait_x_change(0, 200, xc);
        check("dut0_x_after_en_drop", 36'(x0), 36'(32'hFFFF_F923));
        falls = 0; pc = cs0;
        for (int k = 0; k < 2000; k++) begin
            sample_step();
            if (pc && !cs0) falls++;
            pc = cs0;
        end
        check("dut0_no_frames_while_disabled", 36'(falls), 36'(0));

        // Re-enable, then reset in the middle of the conversion
        drive_step(); en0 = 1'b1; e1 = cyc;
        wait_cs_fall(0, 1100, f4);
        check("dut0_tick_after_reenable", 36'(f4 - e1), 36'(1000));
        repeat (40) sample_step();
        @(posedge clk); #1; rst0 = 1'b0; #1;
        check("dut0_async_reset_midframe", act_out(0), RST_OUT);
        repeat (2) drive_step();
        drive_step(); rst0 = 1'b1; rel = cyc;
        wait_cs_fall(0, 1100, f5);
        check("dut0_tick_after_reset", 36'(f5 - rel), 36'(1000));
        wait_x_change(0, 200, xc);
        check("dut0_x_code801", 36'(x0), 36'(1));
        repeat (30) sample_step();
        done0 = 1'b1;
    end

    // Instance 1: SAMPLE_PERIOD=100 (overrun every other tick), SHIFT=4
    initial begin : p_dut1
        int rel, f0, t0;
        repeat (3) drive_step();
        check("dut1_reset_values", act_out(1), RST_OUT);
        drive_step(); rst1 = 1'b1; en1 = 1'b1; rel = cyc;
        wait_cs_fall(1, 200, f0);
        check("dut1_first_tick_delay", 36'(f0 - rel), 36'(100));
        t0 = f0 - 1;
        wait_until(t0 + 100);
        check("dut1_overrun_before_drop", 36'(ov1), 36'(0));
        sample_step();
        check("dut1_overrun_after_drop", 36'(ov1), 36'(1));
        wait_until(t0 + 329);
        check("dut1_x_codeFFF_shift4", 36'(x1), 36'(32'h0000_7FF0));
        sample_step();
        check("dut1_x_code000_shift4", 36'(x1), 36'(32'hFFFF_8000));
        wait_until(rel + 999);
        check("dut1_frames_in_1000_cycles", 36'(aidx[1]), 36'(5));
        done1 = 1'b1;
    end

    initial begin : p_end
        wait (done0 && done1);
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : p_watchdog
        #400000;
        tests++;
        fails++;
        $display("FAIL watchdog: bench did not complete, done0=%0b done1=%0b", done0, done1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
